ascon_rc_sequencer: RTL and testbench

Sequential round-constant engine for the ASCON permutation, and the parametrised successor of the combinational x2 constant-addition stage. It takes a round count (p^a = 12, p^b = 6 or 8, or any legal value up to MAX_ROUNDS) and steps through the round indices. For each round it presents the round constant and applies it to the 64-bit x2 lane, under a valid/ready handshake with the downstream substitution layer. It sits between the permutation controller and the S-box/linear-layer datapath.

---
 rtl/ascon_rc_sequencer.sv | 127 ++++++++++++
 tb/tb_ascon_rc_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_rc_sequencer.sv
// ============================================================================
// Module   : ascon_rc_sequencer
// Brief    : Sequential ASCON round-constant engine applying rc to the x2 lane
//            under a valid/ready handshake. Optional macro: ASCON_RC_ABORT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_rc_sequencer #(
    parameter int MAX_ROUNDS = 12,
    parameter int DATA_W     = 64,
    parameter int RC_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        rounds,
    input  logic [DATA_W-1:0] x2_in,
    output logic [DATA_W-1:0] x2_out,
    output logic [RC_W-1:0]   rc,
    output logic [3:0]        round_idx,
    output logic              rc_valid,
    input  logic              rc_ready,
`ifdef ASCON_RC_ABORT_EN
    input  logic              abort,
`endif
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_max  = 4'(MAX_ROUNDS);
    localparam logic [3:0] c_last = 4'(MAX_ROUNDS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_round_idx;
    logic [3:0]      w_idx_next;
    logic [RC_W-1:0] r_rc;
    logic [RC_W-1:0] w_rc_next;
    logic            r_err;
    logic            w_err_next;
    logic            w_abort;
    logic            w_rounds_ok;

`ifdef ASCON_RC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // rc = 0xF0 - i*0x0F (mod 256), which reduces to {~i, i} nibble pairs
    function automatic logic [7:0] rc_of(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    assign w_rounds_ok = (rounds != 4'd0) && (rounds <= c_max);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_round_idx;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_abort) begin
                    if (w_rounds_ok) begin
                        w_state_next = S_RUN;
                        w_idx_next   = c_max - rounds;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (rc_ready) begin
                    if (r_round_idx == c_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_idx_next = r_round_idx + 4'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_rc_next = RC_W'(rc_of(w_idx_next));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_round_idx <= 4'd0;
            r_rc        <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_round_idx <= w_idx_next;
            r_rc        <= w_rc_next;
            r_err       <= w_err_next;
        end
    end

    assign rc_valid  = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign rc        = r_rc;
    assign round_idx = r_round_idx;
    assign last      = rc_valid && (r_round_idx == c_last);
    assign x2_out    = rc_valid ? (x2_in ^ DATA_W'(r_rc)) : x2_in;

endmodule

`default_nettype wire

// File: tb/tb_ascon_rc_sequencer.sv
// ============================================================================
// Module   : tb_ascon_rc_sequencer
// Brief    : Scoreboard bench for ascon_rc_sequencer (directed stimulus)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_rc_sequencer;

    localparam int MAX_ROUNDS = 12;

    typedef struct packed {
        logic [7:0] rc;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  rounds;
    logic [63:0] x2_in;
    logic [63:0] x2_out;
    logic [7:0]  rc;
    logic [3:0]  round_idx;
    logic        rc_valid;
    logic        rc_ready;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;
`ifdef ASCON_RC_ABORT_EN
    logic        abort;
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    ascon_rc_sequencer #(.MAX_ROUNDS(MAX_ROUNDS), .DATA_W(64), .RC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rounds    (rounds),
        .x2_in     (x2_in),
        .x2_out    (x2_out),
        .rc        (rc),
        .round_idx (round_idx),
        .rc_valid  (rc_valid),
        .rc_ready  (rc_ready),
`ifdef ASCON_RC_ABORT_EN
        .abort     (abort),
`endif
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected constants use the arithmetic form 0xF0 - i*0x0F
    task automatic push_exp(input int r);
        for (int k = MAX_ROUNDS - r; k < MAX_ROUNDS; k++) begin
            exp_t e;
            e.rc   = 8'hF0 - 8'(k) * 8'h0F;
            e.idx  = 4'(k);
            e.last = (k == MAX_ROUNDS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_perm(input int r, input string tag);
        start  = 1'b1;
        rounds = 4'(r);
        push_exp(r);
        step();
        start  = 1'b0;
        chk({tag, "_first_valid"}, 64'(rc_valid), 64'd1);
    endtask

    task automatic run_to_done(input int cnt0, input int exp_cnt, input string tag);
        int cnt   = cnt0;
        int guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            step();
            cnt++;
            guard++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_cycles"}, 64'(cnt), 64'(exp_cnt));
        chk({tag, "_done_valid"}, 64'({rc_valid, busy, last}), 64'd0);
        chk({tag, "_done_x2"}, x2_out, x2_in);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rc_valid === 1'b1 && rc_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(rc), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rc", 64'(rc), 64'(e.rc));
                chk("round_idx", 64'(round_idx), 64'(e.idx));
                chk("last", 64'(last), 64'(e.last));
                chk("x2_out", x2_out, x2_in ^ 64'(e.rc));
            end
        end
    end

    initial begin
        int cnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        rounds   = 4'd0;
        x2_in    = 64'hDEAD_BEEF_0123_4567;
        rc_ready = 1'b1;
`ifdef ASCON_RC_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) step();
        chk("rst_ctrl", 64'({rc_valid, busy, done, err, last}), 64'd0);
        chk("rst_rc_idx", 64'({rc, round_idx}), 64'd0);
        chk("rst_x2", x2_out, x2_in);
        rst_n = 1'b1;
        step();

        // 12 rounds, ready tied high, x2_in zero
        x2_in = 64'd0;
        start_perm(12, "r12");
        chk("r12_x2_first", x2_out, 64'h0000_0000_0000_00F0);
        run_to_done(1, 13, "r12");

        x2_in = 64'h0123_4567_89AB_CDEF;
        start_perm(6, "r6");
        chk("r6_first_idx", 64'(round_idx), 64'd6);
        run_to_done(1, 7, "r6");

        x2_in = 64'hFFFF_0000_FFFF_00FF;
        start_perm(8, "r8");
        chk("r8_first_rc", 64'(rc), 64'hB4);
        run_to_done(1, 9, "r8");

        // Stall three cycles on the second round
        start_perm(6, "stall");
        step();
        cnt = 2;
        rc_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            cnt++;
            chk("stall_rc", 64'(rc), 64'h87);
            chk("stall_idx", 64'(round_idx), 64'd7);
        end
        rc_ready = 1'b1;
        run_to_done(cnt, 10, "stall");

        // Illegal round counts
        start = 1'b1; rounds = 4'd0;
        step();
        start = 1'b0;
        chk("err0", 64'({err, busy, rc_valid}), 64'b100);
        step();
        chk("err0_pulse", 64'({err, busy, rc_valid}), 64'd0);
        start = 1'b1; rounds = 4'd13;
        step();
        start = 1'b0;
        chk("err13", 64'({err, busy, rc_valid}), 64'b100);
        step();
        chk("err13_pulse", 64'({err, busy, rc_valid}), 64'd0);

        // start while busy is ignored
        start_perm(8, "busy_start");
        start = 1'b1; rounds = 4'd12;
        step();
        start = 1'b0;
        chk("busy_start_err", 64'(err), 64'd0);
        run_to_done(2, 9, "busy_start");

        // Asynchronous reset mid-run at the third round
        start_perm(12, "rst_mid");
        step();
        step();
        chk("rst_mid_idx", 64'(round_idx), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_mid_ctrl", 64'({rc_valid, busy, done, err, last}), 64'd0);
        chk("rst_mid_rc_idx", 64'({rc, round_idx}), 64'd0);
        chk("rst_mid_x2", x2_out, x2_in);
        step();
        chk("rst_mid_nodone", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_mid_nodone2", 64'(done), 64'd0);
        start_perm(12, "restart");
        chk("restart_rc", 64'(rc), 64'hF0);
        run_to_done(1, 13, "restart");

`ifdef ASCON_RC_ABORT_EN
        start_perm(12, "abort");
        repeat (9) step();
        chk("abort_idx", 64'(round_idx), 64'd9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sb.delete();
        chk("abort_ctrl", 64'({rc_valid, busy, last, done}), 64'd0);
        step();
        chk("abort_nodone", 64'(done), 64'd0);
        start_perm(8, "abort_restart");
        chk("abort_restart_rc", 64'(rc), 64'hB4);
        run_to_done(1, 9, "abort_restart");
`endif

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
